ds_mod_mc: RTL

- Parametrised successor to the fixed three-register noise-shaping delta-sigma modulator: N-channel, runtime-selectable order 0..3, error-feedback (1-z^-1)^L noise shaping, 1-bit outputs.
- Channels are time-multiplexed round-robin over one shared datapath, one channel update per clk.
- Adds state saturation with a per-channel overload watchdog and sticky overload flags. Sits between the register file and the output pins.

---
 rtl/ds_mc_pkg.sv | 23 ++
 rtl/ds_ef_step.sv | 54 +++++
 rtl/ds_mod_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ds_mc_pkg.sv
// Shared constants and helpers for the multi-channel error-feedback delta-sigma modulator.
package ds_mc_pkg;

    typedef enum logic [1:0] {
        ORD_BYPASS = 2'd0,
        ORD_1      = 2'd1,
        ORD_2      = 2'd2,
        ORD_3      = 2'd3
    } ds_order_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int sat_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sat_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

endpackage

// File: rtl/ds_ef_step.sv
// Combinational single-channel update: (1-z^-1)^L error feedback, 1-bit quantiser,
// saturation of the new error term to the state width.
module ds_ef_step
    import ds_mc_pkg::*;
#(
    parameter int IN_BITS     = 16,
    parameter int SREG_BITS   = 18,
    parameter int DITHER_BITS = 4
) (
    input  logic signed [IN_BITS-1:0]     x,
    input  logic signed [SREG_BITS-1:0]   e1,
    input  logic signed [SREG_BITS-1:0]   e2,
    input  logic signed [SREG_BITS-1:0]   e3,
    input  logic        [1:0]             order,
    input  logic signed [DITHER_BITS-1:0] dither,
    output logic                          b,
    output logic signed [SREG_BITS-1:0]   e_next,
    output logic                          sat
);

    localparam int W = SREG_BITS + 3;
    localparam logic signed [W-1:0] E_MAX = W'(sat_max(SREG_BITS));
    localparam logic signed [W-1:0] E_MIN = W'(sat_min(SREG_BITS));
    localparam logic signed [W-1:0] Q_MAG = W'(sat_max(IN_BITS) + 1);

    logic signed [W-1:0] xw, a1, a2, a3, dw, y, e;

    always_comb begin
        xw = W'(x);
        a1 = W'(e1);
        a2 = W'(e2);
        a3 = W'(e3);
        dw = W'(dither);
        case (order)
            ORD_BYPASS: y = xw;
            ORD_1:      y = xw + a1;
            ORD_2:      y = xw + (a1 <<< 1) - a2;
            default:    y = xw + (a1 <<< 1) + a1 - (a2 <<< 1) - a2 + a3;
        endcase
        y = y + dw;
        b = ~y[W-1];
        e = b ? (y - Q_MAG) : (y + Q_MAG);
        sat    = 1'b0;
        e_next = e[SREG_BITS-1:0];
        if (e > E_MAX) begin
            sat    = 1'b1;
            e_next = E_MAX[SREG_BITS-1:0];
        end else if (e < E_MIN) begin
            sat    = 1'b1;
            e_next = E_MIN[SREG_BITS-1:0];
        end
    end

endmodule

// File: rtl/ds_mod_mc.sv
// N-channel time-multiplexed delta-sigma modulator with overload watchdog.
// Optional LFSR dither before the quantiser when DS_MC_DITHER_EN is defined.
module ds_mod_mc
    import ds_mc_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int IN_BITS     = 16,
    parameter int SREG_BITS   = 18,
    parameter int OVL_LIMIT   = 64,
    parameter int DITHER_BITS = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               ena,
    input  logic [1:0]                                         order,
    input  logic                                               in_valid,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]     in_ch,
    input  logic signed [IN_BITS-1:0]                          in_data,
    input  logic                                               ovl_clr,
    output logic [CHANNELS-1:0]                                ds_out,
    output logic                                               frame_tick,
    output logic [CHANNELS-1:0]                                ovl_sticky
);

    localparam int CH_W  = $clog2(CHANNELS > 1 ? CHANNELS : 2);
    localparam int CNT_W = $clog2(OVL_LIMIT + 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] WD_TRIP = CNT_W'(OVL_LIMIT);

    logic [CH_W-1:0]            ch;
    logic [1:0]                 order_q;
    logic signed [IN_BITS-1:0]  x_q  [CHANNELS];
    logic signed [SREG_BITS-1:0] e1_q [CHANNELS];
    logic signed [SREG_BITS-1:0] e2_q [CHANNELS];
    logic signed [SREG_BITS-1:0] e3_q [CHANNELS];
    logic [CNT_W-1:0]           wd_q [CHANNELS];

    logic                        order_chg, in_ok;
    logic signed [SREG_BITS-1:0] e1_cur, e2_cur, e3_cur, e_next;
    logic [CNT_W-1:0]            wd_cur, wd_inc;
    logic                        b, sat, wd_fire;
    logic signed [DITHER_BITS-1:0] dither;

    assign order_chg = (order != order_q);
    assign in_ok     = int'(in_ch) < CHANNELS;

    // An order change restarts the channel being updated from a clean state.
    assign e1_cur = order_chg ? '0 : e1_q[ch];
    assign e2_cur = order_chg ? '0 : e2_q[ch];
    assign e3_cur = order_chg ? '0 : e3_q[ch];
    assign wd_cur = order_chg ? '0 : wd_q[ch];
    assign wd_inc = wd_cur + 1'b1;
    assign wd_fire = sat && (wd_inc == WD_TRIP);

`ifdef DS_MC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (ena) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign dither = lfsr[DITHER_BITS-1:0];
`else
    assign dither = '0;
`endif

    ds_ef_step #(
        .IN_BITS     (IN_BITS),
        .SREG_BITS   (SREG_BITS),
        .DITHER_BITS (DITHER_BITS)
    ) u_step (
        .x      (x_q[ch]),
        .e1     (e1_cur),
        .e2     (e2_cur),
        .e3     (e3_cur),
        .order  (order),
        .dither (dither),
        .b      (b),
        .e_next (e_next),
        .sat    (sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch         <= '0;
            order_q    <= '0;
            ds_out     <= '0;
            frame_tick <= 1'b0;
            ovl_sticky <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                x_q[i]  <= '0;
                e1_q[i] <= '0;
                e2_q[i] <= '0;
                e3_q[i] <= '0;
                wd_q[i] <= '0;
            end
        end else begin
            if (in_valid && in_ok) begin
                x_q[in_ch] <= in_data;
            end
            if (ovl_clr) begin
                ovl_sticky <= '0;
            end
            frame_tick <= 1'b0;
            if (ena) begin
                order_q    <= order;
                ch         <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                frame_tick <= (ch == '0);
                if (order_chg) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        e1_q[i] <= '0;
                        e2_q[i] <= '0;
                        e3_q[i] <= '0;
                        wd_q[i] <= '0;
                    end
                end
                ds_out[ch] <= b;
                if (sat) begin
                    ovl_sticky[ch] <= 1'b1;
                end
                // Watchdog trip replaces the normal shift with a state flush.
                if (wd_fire) begin
                    e1_q[ch] <= '0;
                    e2_q[ch] <= '0;
                    e3_q[ch] <= '0;
                    wd_q[ch] <= '0;
                end else begin
                    e1_q[ch] <= e_next;
                    e2_q[ch] <= e1_cur;
                    e3_q[ch] <= e2_cur;
                    wd_q[ch] <= sat ? wd_inc : '0;
                end
            end
        end
    end

endmodule
